wb_axis_out: RTL

Write-back output stage, directly downstream of the write-back controller. Paces the controller through `wb_valid_out`, using a credit check against its own FIFO. Selects the addressed 64-bit group from the BS or BP output-buffer read data after the buffer read latency. Streams the words to the output DMA as AXI-Stream, with `tlast` on the final word of each tile.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_fwft_fifo.sv | 63 ++++++
 rtl/wb_axis_out.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the write-back output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  // Width of the output-buffer group index carried by each issue
  localparam int WB_IDX_W  = 3;

  // Native stream/group data width
  localparam int WB_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wb_state_e;

  // One FIFO entry: a stream word and its end-of-tile marker
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic                 last;
  } wb_beat_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwft_fifo
// Description : First-word-fall-through FIFO. The head entry is presented on
//               pop_data whenever the FIFO is non-empty; pop_data reads zero
//               when empty. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwft_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  // Gate the head with empty so the output is a clean zero after reset/drain
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because reads are gated by empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : wb_fwft_fifo
`default_nettype wire

// File: rtl/wb_axis_out.sv
`default_nettype none
// ============================================================================
// Module      : wb_axis_out
// Description : Write-back output stage. Paces the write-back controller with
//               a credit check against the local FIFO, selects the addressed
//               BS/BP group after the buffer read latency and streams words
//               out as AXI-Stream with tlast on the final word of each tile.
//               Optional macro WB_AXIS_PERF_EN adds perf_beats/perf_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_axis_out
  import wb_pkg::*;
#(
  parameter int HW_LUT_PE_COLS = 32,
  parameter int HW_DSP_PE_COLS = 16,
  parameter int DATA_W         = WB_DATA_W,
  parameter int BS_GRPS        = HW_LUT_PE_COLS / 8,
  parameter int BP_GRPS        = HW_DSP_PE_COLS / 4,
  parameter int RD_LAT         = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_tile_start,
  input  logic                      wb_tile_end,
  input  logic                      wb_bs_bp_sel,
  input  logic [WB_IDX_W-1:0]       bs_out_buf_wb_en,
  input  logic [WB_IDX_W-1:0]       bp_out_buf_wb_en,
  input  logic [BS_GRPS*DATA_W-1:0] bs_grp_rdata,
  input  logic [BP_GRPS*DATA_W-1:0] bp_grp_rdata,
  output logic                      wb_valid_out,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      tile_done,
  output logic                      start_busy_err
`ifdef WB_AXIS_PERF_EN
  ,
  output logic [31:0]               perf_beats,
  output logic [31:0]               perf_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LS    = RD_LAT - 1;  // index of the last pipeline stage

  wb_state_e           state;
  wb_state_e           state_nxt;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      credit_used;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [RD_LAT-1:0]   pipe_vld;
  logic [RD_LAT-1:0]   pipe_sel;
  logic [RD_LAT-1:0]   pipe_last;
  logic [WB_IDX_W-1:0] pipe_idx [RD_LAT];
  logic [DATA_W-1:0]   grp_data;
  wb_beat_t            push_beat;
  wb_beat_t            pop_beat;

  // Credit is taken from registered counts only, so a same-cycle pop frees
  // its slot one cycle later
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; a start outside IDLE is ignored here
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wb_tile_start) state_nxt = RUN;
      RUN:     if (wb_valid_out && wb_tile_end) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: issue strobe under credit, drain-complete pulse
  always_comb begin
    wb_valid_out = 1'b0;
    tile_done    = 1'b0;
    case (state)
      RUN:     wb_valid_out = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
      DRAIN:   tile_done    = (inflight == '0) && fifo_empty;
      default: ;
    endcase
  end

  // Sticky flag for a start arriving while a tile is still active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                start_busy_err <= 1'b0;
    else if (wb_tile_start && (state != IDLE)) start_busy_err <= 1'b1;
  end

  // Issue pipeline matching the output-buffer read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_sel  <= '0;
      pipe_last <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_idx[s] <= '0;
    end else begin
      pipe_vld[0]  <= wb_valid_out;
      pipe_sel[0]  <= wb_bs_bp_sel;
      pipe_idx[0]  <= wb_bs_bp_sel ? bs_out_buf_wb_en : bp_out_buf_wb_en;
      pipe_last[0] <= wb_tile_end;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_sel[s]  <= pipe_sel[s-1];
        pipe_idx[s]  <= pipe_idx[s-1];
        pipe_last[s] <= pipe_last[s-1];
      end
    end
  end

  // Count of issues still travelling through the read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({wb_valid_out, pipe_vld[LS]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Group select at the end of the pipeline; out-of-range index reads zero
  always_comb begin
    grp_data = '0;
    if (pipe_sel[LS]) begin
      for (int g = 0; g < BS_GRPS; g++)
        if (pipe_idx[LS] == WB_IDX_W'(g)) grp_data = bs_grp_rdata[g*DATA_W +: DATA_W];
    end else begin
      for (int g = 0; g < BP_GRPS; g++)
        if (pipe_idx[LS] == WB_IDX_W'(g)) grp_data = bp_grp_rdata[g*DATA_W +: DATA_W];
    end
  end

  assign push_beat     = '{data: grp_data, last: pipe_last[LS]};
  assign fifo_push     = pipe_vld[LS] & ~fifo_full;
  assign fifo_pop      = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = pop_beat.data;
  assign m_axis_tlast  = pop_beat.last;

  wb_fwft_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_beat),
    .pop       (fifo_pop),
    .pop_data  (pop_beat),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef WB_AXIS_PERF_EN
  // Handshake and back-pressure counters, cleared at each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else if (wb_tile_start && (state == IDLE)) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (fifo_pop)                        perf_beats <= perf_beats + 32'd1;
      if (m_axis_tvalid && !m_axis_tready) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration
`endif

endmodule : wb_axis_out
`default_nettype wire
